// File: rtl/n_demux.sv
// Registered 1-to-5 demultiplexer: each lane is a one-entry output register with its own handshake.
// Words addressed to lanes 5-7 are always accepted, discarded and tallied in a saturating counter.
module n_demux #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_Dvect,
    input  logic [2:0]       io_sel,
    output logic [WIDTH-1:0] io_Ovect_0,
    output logic [WIDTH-1:0] io_Ovect_1,
    output logic [WIDTH-1:0] io_Ovect_2,
    output logic [WIDTH-1:0] io_Ovect_3,
    output logic [WIDTH-1:0] io_Ovect_4,
    output logic             io_Ovect_0_valid,
    output logic             io_Ovect_1_valid,
    output logic             io_Ovect_2_valid,
    output logic             io_Ovect_3_valid,
    output logic             io_Ovect_4_valid,
    input  logic             io_Ovect_0_ready,
    input  logic             io_Ovect_1_ready,
    input  logic             io_Ovect_2_ready,
    input  logic             io_Ovect_3_ready,
    input  logic             io_Ovect_4_ready,
    output logic [CNT_W-1:0] io_drop_cnt
);

    localparam int LANES = 5;

    logic [WIDTH-1:0] lane_data [LANES];
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] lane_load;
    logic [LANES-1:0] lane_drain;
    logic             sel_ok;
    logic             accept;
    logic [CNT_W-1:0] drop_cnt;

    assign lane_ready = {io_Ovect_4_ready, io_Ovect_3_ready, io_Ovect_2_ready,
                         io_Ovect_1_ready, io_Ovect_0_ready};
    assign sel_ok     = (io_sel < 3'(LANES));
    assign accept     = io_in_valid && io_in_ready;

    // A lane can take a new word when empty or when its consumer drains it this cycle.
    always_comb begin
        io_in_ready = 1'b1;
        lane_load   = '0;
        lane_drain  = lane_valid & lane_ready;
        for (int k = 0; k < LANES; k++) begin
            if (io_sel == 3'(k)) begin
                io_in_ready = !lane_valid[k] || lane_ready[k];
            end
        end
        for (int k = 0; k < LANES; k++) begin
            lane_load[k] = accept && (io_sel == 3'(k));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LANES; k++) begin
                lane_data[k] <= '0;
            end
            lane_valid <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_load[k]) begin
                    lane_data[k]  <= io_Dvect;
                    lane_valid[k] <= 1'b1;
                end else if (lane_drain[k]) begin
                    lane_valid[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (accept && !sel_ok && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    assign io_Ovect_0       = lane_data[0];
    assign io_Ovect_1       = lane_data[1];
    assign io_Ovect_2       = lane_data[2];
    assign io_Ovect_3       = lane_data[3];
    assign io_Ovect_4       = lane_data[4];
    assign io_Ovect_0_valid = lane_valid[0];
    assign io_Ovect_1_valid = lane_valid[1];
    assign io_Ovect_2_valid = lane_valid[2];
    assign io_Ovect_3_valid = lane_valid[3];
    assign io_Ovect_4_valid = lane_valid[4];
    assign io_drop_cnt      = drop_cnt;

endmodule
